// File: rtl/mul_pipe_unit.sv
// Pipelined RV-style multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready handshake,
// global stall and flush. Result appears at the last of STAGES register slices.
module mul_pipe_unit #(
  parameter int unsigned W      = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TW     = 5
) (
  input  logic          cpu_clk,
  input  logic          cpu_rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [TW-1:0] in_tag,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_result,
  output logic [TW-1:0] out_tag,
  output logic          busy
);

  localparam int unsigned PW   = 2 * W;
  localparam int unsigned H    = W / 2;
  localparam int unsigned LAST = STAGES - 1;

  logic              stall;
  logic              accept;
  logic              a_signed;
  logic              b_signed;
  logic signed [W:0] a_ext;
  logic signed [W:0] b_ext;
  logic [PW-1:0]     a_x;
  logic [PW-1:0]     b_lo_x;
  logic [PW-1:0]     b_hi_x;
  logic [PW-1:0]     pp_lo;
  logic [PW-1:0]     pp_hi;
  logic [PW-1:0]     slice0_prod;

  logic [STAGES-1:0] valid_q;
  logic [1:0]        op_q   [STAGES];
  logic [TW-1:0]     tag_q  [STAGES];
  logic [PW-1:0]     prod_q [STAGES];
  logic [PW-1:0]     pp_hi_q;

  assign stall    = valid_q[LAST] & ~out_ready;
  assign in_ready = ~stall & ~flush;
  assign accept   = in_valid & in_ready;

  // B is split into an unsigned low half and a signed high half; both partial
  // products are taken modulo 2^PW, which is exact for the 2W-bit result.
  always_comb begin
    a_signed    = (in_op == 2'b01) || (in_op == 2'b10);
    b_signed    = (in_op == 2'b01);
    a_ext       = $signed({a_signed & in_a[W-1], in_a});
    b_ext       = $signed({b_signed & in_b[W-1], in_b});
    a_x         = {{(PW - W - 1){a_ext[W]}}, a_ext};
    b_lo_x      = {{(PW - H){1'b0}}, b_ext[H-1:0]};
    b_hi_x      = {{(PW - (W + 1 - H)){b_ext[W]}}, b_ext[W:H]};
    pp_lo       = a_x * b_lo_x;
    pp_hi       = (a_x * b_hi_x) << H;
    slice0_prod = (STAGES == 1) ? (pp_lo + pp_hi) : pp_lo;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      valid_q <= '0;
      pp_hi_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        op_q[i]   <= '0;
        tag_q[i]  <= '0;
        prod_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q[0] <= accept;
      if (accept) begin
        op_q[0]   <= in_op;
        tag_q[0]  <= in_tag;
        prod_q[0] <= slice0_prod;
        pp_hi_q   <= pp_hi;
      end
      // Slice 1 completes the sum; later slices only carry the product along.
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          op_q[i]   <= op_q[i-1];
          tag_q[i]  <= tag_q[i-1];
          prod_q[i] <= (i == 1) ? (prod_q[0] + pp_hi_q) : prod_q[i-1];
        end
      end
    end
  end

  assign out_valid  = valid_q[LAST];
  assign out_tag    = tag_q[LAST];
  assign out_result = (op_q[LAST] == 2'b00) ? prod_q[LAST][W-1:0] : prod_q[LAST][PW-1:W];
  assign busy       = |valid_q;

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Randomised and directed bench for mul_pipe_unit against a full-width arithmetic model.
module tb_mul_pipe_unit;

  localparam int W      = 32;
  localparam int STAGES = 3;
  localparam int TW     = 5;

  logic          cpu_clk = 1'b0;
  logic          cpu_rstn = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];

  mul_pipe_unit #(.W(W), .STAGES(STAGES), .TW(TW)) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rstn  (cpu_rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Reference: extend both operands to 2W+2 bits and multiply outright.
  function automatic logic [W-1:0] ref_mul(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [2*W+1:0] sa, sb, p;
    logic as, bs;
    as = (op == 2'd1) || (op == 2'd2);
    bs = (op == 2'd1);
    sa = (as && a[W-1]) ? $signed({{(W+2){1'b1}}, a}) : $signed({{(W+2){1'b0}}, a});
    sb = (bs && b[W-1]) ? $signed({{(W+2){1'b1}}, b}) : $signed({{(W+2){1'b0}}, b});
    p  = sa * sb;
    return (op == 2'd0) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom % 6)
      0: return '0;
      1: return 1;
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      4: return {1'b0, {(W-1){1'b1}}};
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tg, input logic ordy,
                       input logic fl);
    @(negedge cpu_clk);
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    #1;
    cyc++;
  endtask

  task automatic drive_idle(input logic ordy);
    drive(1'b0, 2'($urandom), $urandom, $urandom, TW'($urandom), ordy, 1'b0);
  endtask

  task automatic push_exp(input logic [W-1:0] r);
    if (in_valid && in_ready) exp_q.push_back('{res: r, tag: in_tag, cyc: cyc});
  endtask

  task automatic test_reset();
    exp_t e;
    #1 cpu_rstn = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", out_result); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_tag got %h want 0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    e = '{res: '0, tag: '0, cyc: 0};
    exp_q.delete();
  endtask

  task automatic test_directed();
    logic [1:0]    dop [5] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd1};
    logic [W-1:0]  da  [5] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0]  db  [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF};
    logic [W-1:0]  dr  [5] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    logic [TW-1:0] dt  [5] = '{5'd3, 5'd17, 5'd31, 5'd8, 5'd0};
    exp_t e;
    int idx = 0;
    for (int n = 0; n < 40 && (idx < 5 || exp_q.size() != 0); n++) begin
      if (idx < 5) drive(1'b1, dop[idx], da[idx], db[idx], dt[idx], 1'b1, 1'b0);
      else drive_idle(1'b1);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL directed_extra got %h tag %h want none", out_result, out_tag);
        end else begin
          e = exp_q.pop_front();
          if (out_result !== e.res) begin errors++; $display("FAIL directed_result got %h want %h", out_result, e.res); end
          checks++;
          if (out_tag !== e.tag) begin errors++; $display("FAIL directed_tag got %h want %h", out_tag, e.tag); end
          checks++;
          if (cyc !== e.cyc + STAGES) begin errors++; $display("FAIL directed_latency got %0d want %0d", cyc - e.cyc, STAGES); end
        end
      end
      if (idx < 5 && in_valid && in_ready) begin
        push_exp(dr[idx]);
        idx++;
      end
    end
    checks++;
    if (idx != 5 || exp_q.size() != 0) begin
      errors++; $display("FAIL directed_drain got issued %0d pending %0d want 5 0", idx, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [1:0]    op [5];
    logic [W-1:0]  a  [5];
    logic [W-1:0]  b  [5];
    logic          held = 1'b0;
    logic [W-1:0]  held_res = '0;
    logic [TW-1:0] held_tag = '0;
    exp_t e;
    int idx = 0;
    int done = 0;
    for (int i = 0; i < 5; i++) begin
      op[i] = 2'($urandom); a[i] = rand_operand(); b[i] = rand_operand();
    end
    for (int n = 0; n < 40 && (idx < 5 || exp_q.size() != 0); n++) begin
      if (idx < 5) drive(1'b1, op[idx], a[idx], b[idx], TW'(idx + 20), !(n >= 3 && n <= 6), 1'b0);
      else drive_idle(1'b1);
      if (n >= 3 && n <= 6) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_stalled cycle %0d got %b want 0", n, in_ready); end
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== held_res || out_tag !== held_tag) begin
          errors++; $display("FAIL b2b_head_stable got %b %h %h want 1 %h %h", out_valid, out_result, out_tag, held_res, held_tag);
        end
      end
      held = out_valid && !out_ready; held_res = out_result; held_tag = out_tag;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got %h tag %h want none", out_result, out_tag);
        end else begin
          e = exp_q.pop_front();
          done++;
          if (out_result !== e.res || out_tag !== e.tag) begin
            errors++; $display("FAIL b2b_result got %h tag %h want %h tag %h", out_result, out_tag, e.res, e.tag);
          end
        end
      end
      if (idx < 5 && in_valid && in_ready) begin
        push_exp(ref_mul(op[idx], a[idx], b[idx]));
        idx++;
      end
    end
    checks++;
    if (done != 5 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count got %0d pending %0d want 5 0", done, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic          held = 1'b0;
    logic [W-1:0]  held_res = '0;
    logic [TW-1:0] held_tag = '0;
    exp_t e;
    logic [1:0] op;
    logic [W-1:0] a, b;
    int n = 0;
    while (n < 300 || (exp_q.size() != 0 && n < 340)) begin
      op = 2'($urandom); a = rand_operand(); b = rand_operand();
      if (n < 300) drive(($urandom % 4) != 0, op, a, b, TW'($urandom), ($urandom % 4) != 0, 1'b0);
      else drive(1'b0, op, a, b, TW'($urandom), 1'b1, 1'b0);
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++; $display("FAIL rand_in_ready got %b want %b", in_ready, !(out_valid && !out_ready));
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== held_res || out_tag !== held_tag) begin
          errors++; $display("FAIL rand_head_stable got %b %h %h want 1 %h %h", out_valid, out_result, out_tag, held_res, held_tag);
        end
      end
      held = out_valid && !out_ready; held_res = out_result; held_tag = out_tag;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra got %h tag %h want none", out_result, out_tag);
        end else begin
          e = exp_q.pop_front();
          if (out_result !== e.res || out_tag !== e.tag) begin
            errors++; $display("FAIL rand_result got %h tag %h want %h tag %h", out_result, out_tag, e.res, e.tag);
          end
        end
      end
      push_exp(ref_mul(op, a, b));
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain got pending %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_flush();
    exp_t e;
    logic [W-1:0] a, b;
    int stale = 0;
    int got = 0;
    for (int n = 0; n < 3; n++) begin
      a = rand_operand(); b = rand_operand();
      drive(1'b1, 2'd0, a, b, TW'(n + 1), 1'b1, 1'b0);
      push_exp(ref_mul(2'd0, a, b));
    end
    drive_idle(1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_first_result got valid %b want 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      if (out_result !== e.res || out_tag !== e.tag) begin
        errors++; $display("FAIL flush_first_result got %h tag %h want %h tag %h", out_result, out_tag, e.res, e.tag);
      end
    end
    drive(1'b1, 2'd3, $urandom, $urandom, 5'd9, 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    exp_q.delete();
    drive_idle(1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    for (int n = 0; n < 6; n++) begin
      drive_idle(1'b1);
      if (out_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL flush_stale got %0d results want 0", stale); end
    a = rand_operand(); b = rand_operand();
    drive(1'b1, 2'd1, a, b, 5'd12, 1'b1, 1'b0);
    push_exp(ref_mul(2'd1, a, b));
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) begin
      drive_idle(1'b1);
      if (out_valid) begin
        e = exp_q.pop_front();
        got++;
        checks++;
        if (out_result !== e.res || out_tag !== e.tag) begin
          errors++; $display("FAIL flush_new_op got %h tag %h want %h tag %h", out_result, out_tag, e.res, e.tag);
        end
      end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL flush_new_op_count got %0d want 1", got); end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [W-1:0] a, b;
    int stale = 0;
    int got = 0;
    drive(1'b1, 2'd2, 32'h1234_5678, 32'h9ABC_DEF0, 5'd4, 1'b1, 1'b0);
    drive(1'b1, 2'd0, 32'h0000_0003, 32'h0000_0005, 5'd5, 1'b1, 1'b0);
    drive_idle(1'b1);
    @(posedge cpu_clk);
    #2;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b want 1", out_valid); end
    cpu_rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
    checks++; if (out_result !== '0 || out_tag !== '0) begin
      errors++; $display("FAIL arst_data got %h tag %h want 0 tag 0", out_result, out_tag);
    end
    exp_q.delete();
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    for (int n = 0; n < 8; n++) begin
      drive_idle(1'b1);
      if (out_valid || busy) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL arst_stale got %0d cycles want 0", stale); end
    a = rand_operand(); b = rand_operand();
    drive(1'b1, 2'd0, a, b, 5'd30, 1'b1, 1'b0);
    push_exp(ref_mul(2'd0, a, b));
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) begin
      drive_idle(1'b1);
      if (out_valid) begin
        e = exp_q.pop_front();
        got++;
        checks++;
        if (out_result !== e.res || out_tag !== e.tag) begin
          errors++; $display("FAIL arst_new_op got %h tag %h want %h tag %h", out_result, out_tag, e.res, e.tag);
        end
      end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL arst_new_op_count got %0d want 1", got); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
